// File: rtl/multicycle_control_fsm_pkg.sv
// Shared MIPS control definitions: opcodes, datapath mux encodings, sequencer
// state codes and the bundled control-word type used by the multi-cycle FSM.
package multicycle_control_fsm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ERROR keeps code 11 so existing benches decoding state_dbg still match;
  // JUMP therefore takes the first free code above it.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_ADDI_EXEC = 4'd8,
    S_ADDI_WB   = 4'd9,
    S_BRANCH    = 4'd10,
    S_ERROR     = 4'd11,
    S_JUMP      = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       error;
  } ctrl_t;

  function automatic state_t decode_next(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:     nxt = S_R_EXEC;
      OP_LW, OP_SW: nxt = S_MEM_ADDR;
      OP_ADDI:      nxt = S_ADDI_EXEC;
      OP_BEQ:       nxt = S_BRANCH;
      OP_J:         nxt = S_JUMP;
      default:      nxt = S_ERROR;
    endcase
    return nxt;
  endfunction

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Counts consecutive not-ready cycles spent in a memory state and flags a
// timeout when the count reaches the limit while memory is still not ready.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic in_mem_state,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;
  logic            waiting;

  assign waiting = in_mem_state & ~mem_ready;
  assign timeout = waiting & (count_q == LIMIT);

  // A timeout moves the FSM to ERROR, which is a state change, so clear then too.
  always_comb begin
    count_d = '0;
    if (waiting && !timeout) begin
      count_d = count_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multi-cycle MIPS datapath: steps each instruction
// through fetch/decode/execute/memory/writeback and traps to a sticky ERROR.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       error,
  output logic [3:0] state_dbg
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  ctrl_t  ctrl_out;
  logic   in_mem_state;
  logic   timeout;

  assign in_mem_state = is_mem_state(state_q);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_wait_timer (
    .clk          (clk),
    .reset        (reset),
    .in_mem_state (in_mem_state),
    .mem_ready    (mem_ready),
    .timeout      (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory states: ready always wins over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_ERROR;
      end
      S_DECODE:    state_d = decode_next(op);
      S_MEM_ADDR:  state_d = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (mem_ready)    state_d = S_MEM_WB;
        else if (timeout) state_d = S_ERROR;
      end
      S_MEM_WRITE: begin
        if (mem_ready)    state_d = S_FETCH;
        else if (timeout) state_d = S_ERROR;
      end
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB,
      S_R_WB,
      S_ADDI_WB,
      S_BRANCH,
      S_JUMP:      state_d = S_FETCH;
      S_ERROR:     state_d = S_ERROR;
      default:     state_d = S_ERROR;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_ERROR: begin
        ctrl.error = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

  // Reset masks every strobe immediately so an aborted instruction writes nothing.
  assign ctrl_out = reset ? '0 : ctrl;

  assign PCWrite     = ctrl_out.pc_write;
  assign PCWriteCond = ctrl_out.pc_write_cond;
  assign IorD        = ctrl_out.i_or_d;
  assign MemRead     = ctrl_out.mem_read;
  assign MemWrite    = ctrl_out.mem_write;
  assign IRWrite     = ctrl_out.ir_write;
  assign MemtoReg    = ctrl_out.mem_to_reg;
  assign RegDst      = ctrl_out.reg_dst;
  assign RegWrite    = ctrl_out.reg_write;
  assign ALUSrcA     = ctrl_out.alu_src_a;
  assign ALUSrcB     = ctrl_out.alu_src_b;
  assign ALUOp       = ctrl_out.alu_op;
  assign PCSource    = ctrl_out.pc_source;
  assign instr_done  = ctrl_out.instr_done;
  assign error       = ctrl_out.error;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks hand-written instruction
// sequences and checks state code and the full control word every cycle.
module tb_multicycle_control_fsm;

  localparam int MEM_TIMEOUT = 15;
  localparam int TO_W        = 8;

  // Control word bit order:
  // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite
  // ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0] instr_done error
  localparam logic [17:0] E_ZERO       = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_FETCH_RDY  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] E_FETCH_WAIT = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] E_DECODE     = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] E_MEM_ADDR   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] E_MEM_READ   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_MEM_WB     = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] E_MW_WAIT    = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_MW_RDY     = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] E_R_EXEC     = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] E_R_WB       = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] E_BRANCH     = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] E_JUMP       = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [17:0] E_ERROR      = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEM_ADDR = 4'd2,
                         ST_MEM_READ = 4'd3, ST_MEM_WB = 4'd4, ST_MEM_WRITE = 4'd5,
                         ST_R_EXEC = 4'd6, ST_R_WB = 4'd7, ST_BRANCH = 4'd10,
                         ST_ERROR = 4'd11, ST_JUMP = 4'd12;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, error;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state_dbg;
  logic [17:0] ctl;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .instr_done  (instr_done),
    .error       (error),
    .state_dbg   (state_dbg)
  );

  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, error};

  // Checks the current cycle (inputs already applied), then advances one clock.
  task automatic step(input string tag, input logic [3:0] exp_st, input logic [17:0] exp_ctl);
    #1;
    n_assert++;
    assert (state_dbg === exp_st) else begin
      n_fail++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state_dbg, exp_st);
    end
    n_assert++;
    assert (ctl === exp_ctl) else begin
      n_fail++;
      $error("FAIL %s ctrl: observed %b expected %b", tag, ctl, exp_ctl);
    end
    $display("step %-10s state=%0d ctrl=%b", tag, state_dbg, ctl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    op        = 6'b000000;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step("reset", ST_FETCH, E_ZERO);
    reset = 1'b0;

    // lw with ready held high: 5 cycles
    mem_ready = 1'b1;
    op        = 6'b100011;
    step("lw_fetch", ST_FETCH,    E_FETCH_RDY);
    step("lw_dec",   ST_DECODE,   E_DECODE);
    step("lw_addr",  ST_MEM_ADDR, E_MEM_ADDR);
    step("lw_read",  ST_MEM_READ, E_MEM_READ);
    step("lw_wb",    ST_MEM_WB,   E_MEM_WB);

    // sw with three not-ready cycles in MEM_WRITE
    op = 6'b101011;
    step("sw_fetch", ST_FETCH,    E_FETCH_RDY);
    step("sw_dec",   ST_DECODE,   E_DECODE);
    step("sw_addr",  ST_MEM_ADDR, E_MEM_ADDR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("sw_wait", ST_MEM_WRITE, E_MW_WAIT);
    mem_ready = 1'b1;
    step("sw_done",  ST_MEM_WRITE, E_MW_RDY);

    // R-type, beq, j back to back
    op = 6'b000000;
    step("r_fetch",  ST_FETCH,  E_FETCH_RDY);
    step("r_dec",    ST_DECODE, E_DECODE);
    step("r_exec",   ST_R_EXEC, E_R_EXEC);
    step("r_wb",     ST_R_WB,   E_R_WB);
    op = 6'b000100;
    step("beq_fetch", ST_FETCH,  E_FETCH_RDY);
    step("beq_dec",   ST_DECODE, E_DECODE);
    step("beq_br",    ST_BRANCH, E_BRANCH);
    op = 6'b000010;
    step("j_fetch",  ST_FETCH,  E_FETCH_RDY);
    step("j_dec",    ST_DECODE, E_DECODE);
    step("j_jump",   ST_JUMP,   E_JUMP);

    // illegal opcode traps and stays trapped
    op = 6'b111111;
    step("ill_fetch", ST_FETCH,  E_FETCH_RDY);
    step("ill_dec",   ST_DECODE, E_DECODE);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      step("ill_err", ST_ERROR, E_ERROR);
    end
    reset = 1'b1;
    step("ill_rst", ST_ERROR, E_ZERO);
    reset = 1'b0;

    // fetch timeout: MEM_TIMEOUT+1 not-ready cycles
    op        = 6'b100011;
    mem_ready = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) step("to_wait", ST_FETCH, E_FETCH_WAIT);
    step("to_err", ST_ERROR, E_ERROR);
    reset = 1'b1;
    step("to_rst", ST_ERROR, E_ZERO);
    reset = 1'b0;

    // ready arrives on the very cycle the counter reaches the limit
    for (int i = 0; i < MEM_TIMEOUT; i++) step("edge_wait", ST_FETCH, E_FETCH_WAIT);
    mem_ready = 1'b1;
    step("edge_rdy",  ST_FETCH,    E_FETCH_RDY);
    step("edge_dec",  ST_DECODE,   E_DECODE);
    step("edge_addr", ST_MEM_ADDR, E_MEM_ADDR);

    // reset during MEM_READ aborts the load
    mem_ready = 1'b0;
    step("ab_read", ST_MEM_READ, E_MEM_READ);
    step("ab_read", ST_MEM_READ, E_MEM_READ);
    reset = 1'b1;
    step("ab_rst",  ST_MEM_READ, E_ZERO);
    reset     = 1'b0;
    mem_ready = 1'b1;
    step("ab_fetch", ST_FETCH,  E_FETCH_RDY);
    step("ab_dec",   ST_DECODE, E_DECODE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Moore-style sequencer for the multi-cycle version of the MIPS datapath. It steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB, driving the datapath enables and mux selects.
It stalls on a memory ready handshake and traps illegal opcodes and memory timeouts into a sticky error state. It sits between the instruction register opcode field and the shared datapath (PC, IR, register file, ALU, unified memory).

Parameters:
MEM_TIMEOUT, 15, maximum consecutive cycles a memory state may wait with mem_ready low before trapping to ERROR (1..255)
TO_W, 8, width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
op  input  6  opcode, IR[31:26]; valid from the DECODE state onward
mem_ready  input  1  memory completes the current read/write this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load qualified by the ALU zero flag (beq)
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
MemtoReg  output  1  register write data: 0=ALUOut, 1=MDR
RegDst  output  1  destination register: 0=rt, 1=rd
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU A input: 0=PC, 1=rs
ALUSrcB  output  2  ALU B input: 00=rt, 01=const 4, 10=sign-extended imm, 11=imm<<2
ALUOp  output  2  00=add, 01=sub, 10=funct-decoded
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
instr_done  output  1  one-cycle pulse when an instruction retires
error  output  1  sticky; high in ERROR
state_dbg  output  4  current state encoding

Behaviour:
- Reset: on a clk edge with reset=1, the state becomes FETCH and the wait counter clears. While reset=1, every output except state_dbg is forced to 0 combinationally.
- Outputs are a pure function of the state, plus mem_ready in the memory states.
- States and the outputs that are non-zero in each:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. Go to DECODE on mem_ready, otherwise stay.
  - DECODE: ALUSrcB=11, ALUOp=00. Next state by op:
    - 000000 -> R_EXEC
    - 100011 or 101011 -> MEM_ADDR
    - 001000 -> ADDI_EXEC
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - any other op -> ERROR
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEM_READ if op=100011, else MEM_WRITE.
  - MEM_READ: MemRead=1, IorD=1. Go to MEM_WB on mem_ready.
  - MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Go to FETCH.
  - MEM_WRITE: MemWrite=1, IorD=1, instr_done=mem_ready. Go to FETCH on mem_ready.
  - R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to R_WB.
  - R_WB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Go to FETCH.
  - ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDI_WB.
  - ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Go to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Go to FETCH.
  - JUMP: PCWrite=1, PCSource=10, instr_done=1. Go to FETCH.
  - ERROR: error=1, all other outputs 0. The only exit is reset.
- Latency with mem_ready held high: lw 5 cycles; sw, R-type and addi 4; beq and j 3.
- Wait counter:
  - Increments each cycle in FETCH, MEM_READ or MEM_WRITE while mem_ready=0.
  - Clears on any state change and whenever mem_ready=1.
  - If it equals MEM_TIMEOUT while mem_ready=0, the next state is ERROR instead of staying.
  - mem_ready=1 in that same cycle completes normally (ready wins over timeout).
- mem_ready is ignored outside the memory states.
- op is sampled only in DECODE and MEM_ADDR; IR stability is guaranteed because IRWrite=0 there.
- Reset asserted mid-instruction aborts it: no write strobes are asserted in that cycle, and FETCH begins on the first cycle after reset deasserts.

Decomposition:
- Shared include mips_defs.vh holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J
  - ALUOp encodings
  - ALUSrcB and PCSource encodings
  - 4-bit state encodings: FETCH=0 .. ERROR=11
- These are shared with the single-cycle Control_Unit and its benches.
- One natural sub-module: mem_wait_timer, holding the wait counter and timeout compare, with inputs clk, reset, in_mem_state, mem_ready and output timeout.

Test Plan:
- lw (op=100011), mem_ready=1 -> state_dbg 0,1,2,3,4,0. instr_done high only in cycle 5. MEM_WB has RegWrite=1, MemtoReg=1.
- sw (op=101011), mem_ready low for 3 cycles in MEM_WRITE -> MemWrite held 4 cycles, instr_done on the ready cycle, RegWrite never asserted.
- R-type then beq then j back-to-back, mem_ready=1 -> 4+3+3 cycles. ALUOp=10 in R_EXEC, PCWriteCond=1 with PCSource=01 in BRANCH, PCWrite=1 with PCSource=10 in JUMP.
- op=111111 in DECODE -> ERROR next cycle, error=1 and sticky for 20 cycles. reset=1 for one cycle -> FETCH, error=0.
- FETCH with mem_ready=0 for MEM_TIMEOUT+1 cycles -> ERROR. A repeat run with ready arriving on the MEM_TIMEOUT-th wait cycle -> DECODE, no error.
- reset asserted in MEM_READ -> all outputs 0 during reset, FETCH afterward, no RegWrite pulse for the aborted lw.
